// File: rtl/hazard_pkg.sv
// hazard_pkg: shared pipeline types and constants for the hazard controller.
package hazard_pkg;
  typedef enum logic [1:0] {RUN, MEM_WAIT, ERROR} state_e;
  localparam int REG_W = 5;
  localparam logic [REG_W-1:0] X0 = '0;
endpackage

// File: rtl/hazard_detect.sv
// hazard_detect: combinational load-use comparator between ID/EX load and IF/ID sources.
module hazard_detect
  import hazard_pkg::*;
(
  input  logic [REG_W-1:0] ifid_rs1,
  input  logic [REG_W-1:0] ifid_rs2,
  input  logic             ifid_use_rs1,
  input  logic             ifid_use_rs2,
  input  logic             idex_memread,
  input  logic [REG_W-1:0] idex_rd,
  output logic             load_use
);
  assign load_use = idex_memread && idex_rd != X0 &&
                    ((ifid_use_rs1 && ifid_rs1 == idex_rd) || (ifid_use_rs2 && ifid_rs2 == idex_rd));
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline stall/flush control with data-memory wait FSM, bus timeout and stall counter.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] ifid_rs1,
  input  logic [REG_W-1:0] ifid_rs2,
  input  logic             ifid_use_rs1,
  input  logic             ifid_use_rs2,
  input  logic             idex_memread,
  input  logic [REG_W-1:0] idex_rd,
  input  logic             ex_branch_taken,
  input  logic             exmem_memreq,
  input  logic             dmem_ack,
  output logic             dmem_req,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             memwb_flush,
  output logic             bus_error,
  output logic [15:0]      stall_count
);
  localparam logic [7:0] TIMEOUT = 8'(TIMEOUT_CYCLES);
  state_e      state_q, state_d;
  logic [7:0]  wait_q, wait_d;
  logic        bus_error_q, bus_error_d;
  logic [15:0] stall_q, stall_d;
  logic        load_use, err, mem_stall;
  hazard_detect u_detect (
    .ifid_rs1     (ifid_rs1),
    .ifid_rs2     (ifid_rs2),
    .ifid_use_rs1 (ifid_use_rs1),
    .ifid_use_rs2 (ifid_use_rs2),
    .idex_memread (idex_memread),
    .idex_rd      (idex_rd),
    .load_use     (load_use)
  );
  // An unacknowledged access stalls from the very cycle it is issued in RUN.
  assign err       = state_q == ERROR;
  assign mem_stall = !dmem_ack && ((state_q == RUN && exmem_memreq) || state_q == MEM_WAIT);
  assign dmem_req    = reset && ((state_q == RUN && exmem_memreq) || state_q == MEM_WAIT);
  assign pc_en       = reset && !err && !mem_stall && (ex_branch_taken || !load_use);
  assign ifid_en     = pc_en;
  assign idex_en     = reset && !err && !mem_stall;
  assign exmem_en    = idex_en;
  assign memwb_en    = reset && !err;
  assign ifid_flush  = !reset || (!err && !mem_stall && ex_branch_taken);
  assign idex_flush  = !reset || (!err && !mem_stall && (ex_branch_taken || load_use));
  assign memwb_flush = !reset || mem_stall;
  assign bus_error   = bus_error_q;
  assign stall_count = stall_q;
  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    bus_error_d = bus_error_q;
    stall_d     = (!pc_en && stall_q != 16'hFFFF) ? stall_q + 16'd1 : stall_q;
    case (state_q)
      RUN: if (exmem_memreq && !dmem_ack) begin
        state_d = MEM_WAIT;
        wait_d  = 8'd1;
      end
      MEM_WAIT: if (dmem_ack) state_d = RUN;
      else if (wait_q == TIMEOUT) begin
        state_d     = ERROR;
        bus_error_d = 1'b1;
      end else wait_d = wait_q + 8'd1;
      default: state_d = ERROR;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= RUN;
      wait_q      <= '0;
      bus_error_q <= 1'b0;
      stall_q     <= '0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      bus_error_q <= bus_error_d;
      stall_q     <= stall_d;
    end
  end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed-vector check of hazard_ctrl with TIMEOUT_CYCLES=4.
module tb_hazard_ctrl;
  import hazard_pkg::*;
  logic clk = 1'b0;
  logic reset;
  logic [4:0] ifid_rs1, ifid_rs2, idex_rd;
  logic ifid_use_rs1, ifid_use_rs2, idex_memread, ex_branch_taken, exmem_memreq, dmem_ack;
  logic dmem_req, pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic ifid_flush, idex_flush, memwb_flush, bus_error;
  logic [15:0] stall_count;
  logic [8:0] ctl;
  int checks = 0;
  int failures = 0;
  // {dmem_req, pc, ifid, idex, exmem, memwb enables, ifid/idex/memwb flushes}
  localparam logic [8:0] IDLE   = 9'b0_11111_000;
  localparam logic [8:0] RSTV   = 9'b0_00000_111;
  localparam logic [8:0] LDUSE  = 9'b0_00111_010;
  localparam logic [8:0] BRANCH = 9'b0_11111_110;
  localparam logic [8:0] MSTALL = 9'b1_00001_001;
  localparam logic [8:0] ACKBR  = 9'b1_11111_110;
  localparam logic [8:0] ERRV   = 9'b0_00000_000;
  always #5 clk = ~clk;
  assign ctl = {dmem_req, pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, memwb_flush};
  hazard_ctrl #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset(reset),
    .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2),
    .ifid_use_rs1(ifid_use_rs1), .ifid_use_rs2(ifid_use_rs2),
    .idex_memread(idex_memread), .idex_rd(idex_rd),
    .ex_branch_taken(ex_branch_taken), .exmem_memreq(exmem_memreq), .dmem_ack(dmem_ack),
    .dmem_req(dmem_req), .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en),
    .exmem_en(exmem_en), .memwb_en(memwb_en),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush), .memwb_flush(memwb_flush),
    .bus_error(bus_error), .stall_count(stall_count)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    {ifid_rs1, ifid_rs2, idex_rd} = '0;
    {ifid_use_rs1, ifid_use_rs2, idex_memread, ex_branch_taken, exmem_memreq, dmem_ack} = '0;
  endtask
  task automatic load_use(input logic [4:0] rd, input logic [4:0] rs1, input logic u1,
                          input logic [4:0] rs2, input logic u2);
    idex_memread = 1'b1;
    idex_rd = rd;
    ifid_rs1 = rs1;
    ifid_use_rs1 = u1;
    ifid_rs2 = rs2;
    ifid_use_rs2 = u2;
  endtask
  initial begin
    idle();
    reset = 1'b0;
    #2;
    chk("reset_ctl", 32'(ctl), 32'(RSTV));
    tick();
    tick();
    chk("reset_stall", 32'(stall_count), 0);
    chk("reset_buserr", 32'(bus_error), 0);
    reset = 1'b1;
    #1 chk("idle", 32'(ctl), 32'(IDLE));
    load_use(5'd5, 5'd0, 1'b0, 5'd5, 1'b1);
    #1 chk("loaduse_rs2", 32'(ctl), 32'(LDUSE));
    tick();
    idle();
    #1 chk("loaduse_release", 32'(ctl), 32'(IDLE));
    chk("loaduse_count", 32'(stall_count), 1);
    load_use(5'd0, 5'd0, 1'b1, 5'd3, 1'b0);
    #1 chk("x0_load", 32'(ctl), 32'(IDLE));
    load_use(5'd7, 5'd7, 1'b0, 5'd3, 1'b1);
    #1 chk("unused_rs1", 32'(ctl), 32'(IDLE));
    load_use(5'd9, 5'd9, 1'b1, 5'd0, 1'b0);
    #1 chk("loaduse_rs1", 32'(ctl), 32'(LDUSE));
    ex_branch_taken = 1'b1;
    #1 chk("branch_wins", 32'(ctl), 32'(BRANCH));
    tick();
    idle();
    #1 chk("branch_nostall", 32'(stall_count), 1);
    exmem_memreq = 1'b1;
    #1 chk("mem_issue_stall", 32'(ctl), 32'(MSTALL));
    tick();
    load_use(5'd5, 5'd5, 1'b1, 5'd0, 1'b0);
    ex_branch_taken = 1'b1;
    #1 chk("memwait1_suppress", 32'(ctl), 32'(MSTALL));
    tick();
    #1 chk("memwait2", 32'(ctl), 32'(MSTALL));
    tick();
    dmem_ack = 1'b1;
    #1 chk("memwait_ack_branch", 32'(ctl), 32'(ACKBR));
    chk("memwait_count", 32'(stall_count), 4);
    tick();
    idle();
    #1 chk("memwait_back_run", 32'(ctl), 32'(IDLE));
    chk("memwait_count_hold", 32'(stall_count), 4);
    exmem_memreq = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1 chk($sformatf("timeout_stall%0d", i), 32'(ctl), 32'(MSTALL));
      chk($sformatf("timeout_buserr%0d", i), 32'(bus_error), 0);
      tick();
    end
    #1 chk("error_ctl", 32'(ctl), 32'(ERRV));
    chk("error_buserr", 32'(bus_error), 1);
    chk("error_count", 32'(stall_count), 9);
    dmem_ack = 1'b1;
    tick();
    tick();
    idle();
    dmem_ack = 1'b1;
    #1 chk("error_held", 32'(ctl), 32'(ERRV));
    chk("error_held_buserr", 32'(bus_error), 1);
    chk("error_count_grows", 32'(stall_count), 11);
    reset = 1'b0;
    #1 chk("reset_in_error", 32'(ctl), 32'(RSTV));
    tick();
    reset = 1'b1;
    idle();
    #1 chk("error_reset_ctl", 32'(ctl), 32'(IDLE));
    chk("error_reset_buserr", 32'(bus_error), 0);
    chk("error_reset_count", 32'(stall_count), 0);
    exmem_memreq = 1'b1;
    tick();
    tick();
    #1 chk("midwait_count", 32'(stall_count), 2);
    reset = 1'b0;
    #1 chk("midwait_reset_ctl", 32'(ctl), 32'(RSTV));
    tick();
    reset = 1'b1;
    idle();
    #1 chk("midwait_reset_run", 32'(ctl), 32'(IDLE));
    chk("midwait_reset_count", 32'(stall_count), 0);
    chk("midwait_reset_buserr", 32'(bus_error), 0);
    exmem_memreq = 1'b1;
    dmem_ack = 1'b1;
    #1 chk("mem_ack_same_cycle", 32'(ctl), 32'(9'b1_11111_000));
    dmem_ack = 1'b0;
    repeat (5) tick();
    idle();
    repeat (65540) tick();
    #1 chk("stall_saturate", 32'(stall_count), 32'hFFFF);
    chk("saturate_error", 32'(ctl), 32'(ERRV));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16: max wait cycles for dmem_ack before bus error (range 1..255).
REQ-002 clk  input  1  pipeline clock; all state updates on posedge clk.
REQ-003 reset  input  1  synchronous, active-low reset.
REQ-004 ifid_rs1, ifid_rs2  input  5 each  source registers of the instruction in IF/ID.
REQ-005 ifid_use_rs1, ifid_use_rs2  input  1 each  the IF/ID instruction actually reads rs1/rs2.
REQ-006 idex_memread  input  1  the ID/EX instruction is a load; idex_rd  input  5  its destination.
REQ-007 ex_branch_taken  input  1  branch/jump resolved taken in EX this cycle.
REQ-008 exmem_memreq  input  1  the EX/MEM instruction accesses data memory; dmem_ack  input  1  memory completes the access this cycle.
REQ-009 dmem_req  output  1  data-memory request strobe.
REQ-010 pc_en, ifid_en, idex_en, exmem_en, memwb_en  output  1 each  register load enables.
REQ-011 ifid_flush, idex_flush, memwb_flush  output  1 each  load a bubble (all-zero control) instead of data.
REQ-012 bus_error  output  1  sticky memory-timeout flag; stall_count  output  16  saturating stall-cycle count.

Function
REQ-013 FSM states RUN, MEM_WAIT, ERROR; all control outputs are combinational from state and inputs, zero-cycle latency.
REQ-014 RUN, exmem_memreq=1: dmem_req=1; if dmem_ack=0 the same cycle -> MEM_WAIT, wait counter loads 1; if dmem_ack=1 stay RUN, no stall.
REQ-015 MEM_WAIT: dmem_req=1; pc_en, ifid_en, idex_en, exmem_en = 0; memwb_en=1 with memwb_flush=1; load-use and branch rules suppressed.
REQ-016 MEM_WAIT, dmem_ack=1: that cycle behaves as RUN with the memory stall released (all enables 1, hazard rules REQ-018..020 apply); next state RUN.
REQ-017 MEM_WAIT, dmem_ack=0 and wait counter = TIMEOUT_CYCLES -> ERROR, bus_error set; otherwise counter increments.
REQ-018 Load-use hazard: idex_memread=1 and idex_rd!=0 and ((ifid_use_rs1 and ifid_rs1==idex_rd) or (ifid_use_rs2 and ifid_rs2==idex_rd)) -> pc_en=0, ifid_en=0, idex_flush=1; exmem/memwb proceed.
REQ-019 ex_branch_taken=1 -> ifid_flush=1, idex_flush=1, pc_en=1.
REQ-020 Branch and load-use same cycle: branch wins (REQ-019 only; IF/ID instruction is wrong-path).
REQ-021 No hazard, RUN: all enables 1, all flushes 0.
REQ-022 ERROR: all enables 0, dmem_req=0, flushes 0, bus_error=1; exits only by reset.
REQ-023 Flush asserted implies the matching enable is 1.
REQ-024 stall_count increments each cycle pc_en=0 outside reset, saturates at 0xFFFF, never wraps.

Reset
REQ-025 reset=0 at a posedge: state<=RUN, wait counter<=0, bus_error<=0, stall_count<=0, from any state including mid-MEM_WAIT and ERROR.
REQ-026 While reset=0: all enables 0, all flushes 1, dmem_req=0.

Structure
REQ-027 Shared pipeline package holds the FSM state enum, the 5-bit register-index width, and the x0 constant.
REQ-028 Single sub-module hazard_detect (combinational load-use comparator, REQ-018); FSM, counters and priority in hazard_ctrl.

Verification
REQ-029 Load-use: idex_memread=1, idex_rd=5, ifid_rs2=5, ifid_use_rs2=1 -> one cycle pc_en=0, ifid_en=0, idex_flush=1; stall_count=1.
REQ-030 x0 load: idex_rd=0, ifid_rs1=0, ifid_use_rs1=1 -> no stall, all enables 1.
REQ-031 Memory wait: exmem_memreq=1, dmem_ack low 3 cycles then high -> 3 cycles MEM_WAIT with memwb_flush=1, release on cycle 4; stall_count=3.
REQ-032 Timeout: TIMEOUT_CYCLES=4, exmem_memreq=1, dmem_ack never -> ERROR after 5 stalled cycles, bus_error=1, dmem_req=0, held until reset.
REQ-033 Branch plus load-use same cycle -> ifid_flush=1, idex_flush=1, pc_en=1, no stall; branch pending during MEM_WAIT applies on the ack cycle.
REQ-034 Reset mid-MEM_WAIT (cycle 2) -> next cycle RUN, stall_count=0, bus_error=0, dmem_req=0 while reset=0.
